ysyx_23060096_regfile_sb: RTL and testbench
===========================================

YSYX_23060096_REGFILE_SB -- requirements
Module: ysyx_23060096_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ready, output, 1, high when initialisation is complete and the file accepts traffic.
REQ-007 SHALL have port w_en, input, 1, write strobe.
REQ-008 SHALL have port waddr, input, ADDR_WIDTH, write index.
REQ-009 SHALL have port wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have ports Ra and Rb, input, ADDR_WIDTH each, read indices.
REQ-011 SHALL have ports busA and busB, output, DATA_WIDTH each, read data.
REQ-012 SHALL have port iss_valid, input, 1, instruction-issue strobe that marks a destination pending.
REQ-013 SHALL have port iss_rd, input, ADDR_WIDTH, destination index being issued.
REQ-014 SHALL have ports busyA and busyB, output, 1 each, pending-write flag for Ra and Rb.

Function
REQ-015 SHALL implement a two-state FSM with states INIT and RUN.
REQ-016 SHALL be in INIT with ready low while the FSM is in INIT; ready SHALL be high only in RUN.
REQ-017 In INIT with rst low, the block SHALL clear rf[cnt] to 0 and increment the ADDR_WIDTH-bit counter cnt once per cycle.
REQ-018 SHALL transition INIT->RUN on the edge that clears entry DEPTH-1, so ready rises exactly DEPTH edges after rst is first sampled low.
REQ-019 SHALL remain in RUN until rst is sampled high; RUN has no other exit.
REQ-020 In INIT, the block SHALL ignore w_en and iss_valid, and SHALL drive busA, busB, busyA and busyB to 0.
REQ-021 In RUN, when w_en is high and waddr != 0, the block SHALL write rf[waddr] <= wdata on the edge.
REQ-022 Index 0 SHALL read as 0 at all times; writes to index 0 SHALL be dropped.
REQ-023 Reads SHALL be combinational: busA = rf[Ra] and busB = rf[Rb], subject to REQ-022 and REQ-031.
REQ-024 SHALL keep one busy bit per index; busy[0] SHALL be constantly 0.
REQ-025 In RUN, iss_valid with iss_rd != 0 SHALL set busy[iss_rd] on the edge; re-issuing an already-busy index SHALL leave it set (no count).
REQ-026 In RUN, a write with w_en high and waddr != 0 SHALL clear busy[waddr] on the edge.
REQ-027 If a set and a clear target the same index in the same cycle, the set SHALL win and the bit SHALL end high.
REQ-028 SHALL drive busyA = busy[Ra] and busyB = busy[Rb] combinationally, with no bypass of same-cycle set/clear.
REQ-029 Writes to a non-busy index SHALL be legal and update the data.

Reset
REQ-030 While rst is sampled high, the block SHALL: enter INIT, set cnt to 0, clear all busy bits in that edge, and drive ready low; register contents are undefined until INIT completes. Asserting rst in RUN or mid-INIT SHALL restart the full DEPTH-cycle clear.

Configuration
REQ-031 With macro YSYX_23060096_RF_BYPASS_EN defined, in RUN, when w_en is high, waddr != 0 and waddr equals Ra (or Rb), the block SHALL drive busA (or busB) from wdata in the same cycle.
REQ-032 With YSYX_23060096_RF_BYPASS_EN undefined, reads SHALL return only stored contents, so a write becomes visible on the cycle after its edge.

Verification
REQ-033 Reset and init: rst high for 2 cycles, then low -> ready is 0 for 32 edges, rises on the 32nd edge; all reads return 0 and all busy flags are 0.
REQ-034 Write and read back: w_en=1, waddr=5, wdata=0xDEADBEEF, then Ra=5 on the next cycle -> busA=0xDEADBEEF; a write of 0x1234 to waddr=0 leaves busA=0 when Ra=0.
REQ-035 Bypass: same cycle w_en=1, waddr=7, wdata=0xA5A5A5A5, Rb=7 -> busB=0xA5A5A5A5 when the bypass macro is defined; busB shows the old value when it is undefined.
REQ-036 Scoreboard: iss_valid=1, iss_rd=3 -> busyA=1 for Ra=3 next cycle; a write to waddr=3 -> busyA=0 next cycle; iss_rd=3 and waddr=3 in the same cycle -> busyA stays 1.
REQ-037 Reset mid-operation: in RUN with busy[9] set and rf[9]=0x55, assert rst for 1 cycle -> busy[9]=0 immediately, ready low for 32 edges, then rf[9] reads 0.

Source files
------------

// File: rtl/ysyx_23060096_regfile_sb.sv
// Register file with a per-index pending-write scoreboard and a power-up clear sequence.
// Define YSYX_23060096_RF_BYPASS_EN to forward same-cycle write data onto the read buses.
module ysyx_23060096_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  busyA,
    output logic                  busyB
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic [DATA_WIDTH-1:0]   rf [DEPTH];
    logic [DEPTH-1:0]        busy_reg;
    logic [DEPTH-1:0]        busy_next;
    logic                    run;
    logic                    wr_hit;

    assign run    = (state_reg == RUN);
    assign wr_hit = w_en && (waddr != '0);

    always_ff @(posedge clk) begin
        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        if (rst) begin
            state_next = INIT;
        end else begin
            case (state_reg)
                INIT: if (cnt_reg == ADDR_WIDTH'(DEPTH - 1)) state_next = RUN;
                RUN:  state_next = RUN;
                default: state_next = INIT;
            endcase
        end
        if (state_reg == RUN) ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == INIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Storage has no reset: the INIT sweep is what brings every entry to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                rf[cnt_reg] <= '0;
            end else if (wr_hit) begin
                rf[waddr] <= wdata;
            end
        end
    end

    // Set has priority over clear so a re-issue racing an older write stays pending.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_idx
                logic set_hit;
                logic clr_hit;
                assign set_hit = iss_valid && (iss_rd == ADDR_WIDTH'(gi));
                assign clr_hit = wr_hit && (waddr == ADDR_WIDTH'(gi));
                assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else if (run) begin
            busy_reg <= busy_next;
        end
    end

    always_comb begin
        busA  = '0;
        busB  = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        if (run) begin
            busyA = busy_reg[Ra];
            busyB = busy_reg[Rb];
            if (Ra != '0) begin
                busA = rf[Ra];
`ifdef YSYX_23060096_RF_BYPASS_EN
                if (w_en && (waddr == Ra)) busA = wdata;
`endif
            end
            if (Rb != '0) begin
                busB = rf[Rb];
`ifdef YSYX_23060096_RF_BYPASS_EN
                if (w_en && (waddr == Rb)) busB = wdata;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060096_regfile_sb.sv
// Directed bench for ysyx_23060096_regfile_sb: init sweep, read/write, bypass, scoreboard, reset mid-run.
module tb_ysyx_23060096_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        w_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        busyA;
    logic        busyB;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ysyx_23060096_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .w_en(w_en), .waddr(waddr), .wdata(wdata),
        .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busyA(busyA), .busyB(busyB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] byp_exp;
        rst = 1'b1; w_en = 1'b0; waddr = '0; wdata = '0;
        Ra = '0; Rb = '0; iss_valid = 1'b0; iss_rd = '0;

        // Reset and init sweep
        tick(); tick();
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_busyA", {31'b0, busyA}, 32'd0);
        rst = 1'b0;
        Ra = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("init_ready_e%0d", k), {31'b0, ready}, (k == 32) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            Ra = 5'(i); Rb = 5'(31 - i);
            #1;
            check($sformatf("init_busA_r%0d", i), busA, 32'd0);
            check($sformatf("init_busyB_r%0d", 31 - i), {31'b0, busyB}, 32'd0);
        end

        // Write and read back
        w_en = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; Ra = 5'd5;
`ifdef YSYX_23060096_RF_BYPASS_EN
        byp_exp = 32'hDEADBEEF;
`else
        byp_exp = 32'd0;
`endif
        #1;
        check("wr5_same_cycle", busA, byp_exp);
        tick();
        w_en = 1'b0; #1;
        check("wr5_readback", busA, 32'hDEADBEEF);
        w_en = 1'b1; waddr = 5'd0; wdata = 32'h1234; Ra = 5'd0;
        tick();
        w_en = 1'b0; #1;
        check("wr0_dropped", busA, 32'd0);

        // Bypass on port B
        w_en = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        wdata = 32'hA5A5A5A5; Rb = 5'd7;
`ifdef YSYX_23060096_RF_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h11111111;
`endif
        #1;
        check("bypass_busB", busB, byp_exp);
        tick();
        w_en = 1'b0; #1;
        check("wr7_readback", busB, 32'hA5A5A5A5);

        // Scoreboard set / hold / clear / set-wins
        iss_valid = 1'b1; iss_rd = 5'd3; Ra = 5'd3; Rb = 5'd3;
        #1;
        check("busy3_no_bypass", {31'b0, busyA}, 32'd0);
        tick();
        iss_valid = 1'b0; #1;
        check("busy3_set", {31'b0, busyA}, 32'd1);
        check("busy3_setB", {31'b0, busyB}, 32'd1);
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0; #1;
        check("busy3_reissue", {31'b0, busyA}, 32'd1);
        w_en = 1'b1; waddr = 5'd3; wdata = 32'h33;
        tick();
        w_en = 1'b0; #1;
        check("busy3_cleared", {31'b0, busyA}, 32'd0);
        check("wr3_data", busA, 32'h33);
        iss_valid = 1'b1; w_en = 1'b1; waddr = 5'd3; wdata = 32'h34;
        tick();
        iss_valid = 1'b0; w_en = 1'b0; #1;
        check("busy3_set_wins", {31'b0, busyA}, 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd0; Ra = 5'd0;
        tick();
        iss_valid = 1'b0; #1;
        check("busy0_const", {31'b0, busyA}, 32'd0);

        // Reset mid-operation
        w_en = 1'b1; waddr = 5'd9; wdata = 32'h55;
        tick();
        w_en = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0; Ra = 5'd9; #1;
        check("rf9_before", busA, 32'h55);
        check("busy9_before", {31'b0, busyA}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("busy9_after_rst", {31'b0, busyA}, 32'd0);
        check("busA_in_init", busA, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                w_en = 1'b1; waddr = 5'd2; wdata = 32'hFFFF;
                iss_valid = 1'b1; iss_rd = 5'd2;
            end else begin
                w_en = 1'b0; iss_valid = 1'b0;
            end
            tick();
            check($sformatf("reinit_ready_e%0d", k), {31'b0, ready}, (k == 32) ? 32'd1 : 32'd0);
        end
        w_en = 1'b0; iss_valid = 1'b0; Ra = 5'd9; Rb = 5'd2; #1;
        check("rf9_cleared", busA, 32'd0);
        check("rf2_init_write_ignored", busB, 32'd0);
        check("busy2_init_issue_ignored", {31'b0, busyB}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
